// File: rtl/jpl_adc_spi_reader.sv
// jpl_adc_spi_reader
//   Periodic SPI front end for a multiplexed 12-bit SAR ADC (ADC128S022-class
//   framing). It frames one conversion per period, steers the ADC input mux
//   over MOSI, and emits each result as a one-cycle o_adc_raw_valid strobe
//   with a channel tag. The result of frame k belongs to the channel that was
//   addressed in frame k-1, so the mux address always runs one channel ahead.
//
//   Optional build macro: JPL_ADC_SPI_LEADCHK_EN
//     When defined, a 1 on any leading (non-result) frame bit turns the
//     frame's strobe into an o_fault_frame pulse. When undefined, leading
//     bits are ignored and o_fault_frame is tied low.
//
// Ports
//   i_clk, i_rst_n       system clock, asynchronous active-low reset
//   i_enable             run periodic scanning
//   i_period             i_clk cycles between frame starts (latched per frame)
//   o_spi_cs_n/sclk/mosi SPI master outputs, CPOL=1
//   i_spi_miso           ADC serial data
//   o_adc_raw/_valid     last result and its one-cycle strobe
//   o_adc_chan           channel tag of o_adc_raw
//   o_busy               frame machinery not idle
//   o_fault_overrun      sticky: latched period shorter than one frame
//   o_fault_frame        one-cycle pulse: leading-bit error

module jpl_adc_spi_reader #(
    parameter int B        = 12,
    parameter int N        = 2,
    parameter int ADDR_W   = 3,
    parameter int ADDR_POS = 2,
    parameter int FRAME    = 16,
    parameter int CLKDIV   = 4,
    localparam int CW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_enable,
    input  logic [15:0]   i_period,
    output logic          o_spi_cs_n,
    output logic          o_spi_sclk,
    output logic          o_spi_mosi,
    input  logic          i_spi_miso,
    output logic [B-1:0]  o_adc_raw,
    output logic          o_adc_raw_valid,
    output logic [CW-1:0] o_adc_chan,
    output logic          o_busy,
    output logic          o_fault_overrun,
    output logic          o_fault_frame
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BW = $clog2(FRAME + 1);
    localparam int LEAD = FRAME - B;
    // Shortest achievable frame-to-frame spacing: CS-low time plus QUIET.
    localparam logic [31:0] PMIN = 32'(CLKDIV * (2 * FRAME + 3));
    // Left shift that puts the address MSB at frame bit ADDR_POS.
    localparam int SH = FRAME - ADDR_POS - ADDR_W;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, QUIET} state_t;

    state_t            state;
    logic [DW-1:0]     div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [FRAME-1:0]  tx_sh;
    logic [B-1:0]      rx_sh;
    logic [15:0]       per_cnt;
    logic [15:0]       per_q;
    logic              run;        // scanning since the last enable rise
    logic [CW-1:0]     chan_q;     // k mod N for the frame in flight / next frame

    logic              cs_n_q, sclk_q, mosi_q, valid_q, busy_q, ovr_q;
    logic [B-1:0]      raw_q;
    logic [CW-1:0]     chan_o_q;

    logic              div_last, expired, start;
    logic [CW-1:0]     chan_nxt;
    logic [FRAME-1:0]  tx_load;

`ifdef JPL_ADC_SPI_LEADCHK_EN
    logic              lead_err;
    logic              ffr_q;
`endif

    always_comb begin
        div_last = (div_cnt == DW'(CLKDIV - 1));
        // The count that is reached on the next cycle decides the start, so
        // CS falls exactly i_period cycles after the previous CS fall.
        expired  = !run || (({1'b0, per_cnt} + 17'd1) >= {1'b0, per_q});
        start    = i_enable && expired &&
                   ((state == IDLE) || ((state == QUIET) && div_last));
        chan_nxt = (chan_q == CW'(N - 1)) ? '0 : chan_q + 1'b1;
        tx_load  = FRAME'(ADDR_W'(chan_nxt)) << SH;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            per_cnt  <= '0;
            per_q    <= '0;
            run      <= 1'b0;
            chan_q   <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            mosi_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            raw_q    <= '0;
            chan_o_q <= '0;
`ifdef JPL_ADC_SPI_LEADCHK_EN
            lead_err <= 1'b0;
            ffr_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef JPL_ADC_SPI_LEADCHK_EN
            ffr_q   <= 1'b0;
`endif
            if (per_cnt != '1)
                per_cnt <= per_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (!i_enable) begin
                        run    <= 1'b0;
                        chan_q <= '0;
                        ovr_q  <= 1'b0;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        state   <= SHIFT;
                        sclk_q  <= 1'b0;
                        mosi_q  <= tx_sh[FRAME-1];
                        tx_sh   <= tx_sh << 1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (!sclk_q) begin
                            // This edge drives SCLK high: capture MISO now.
                            sclk_q  <= 1'b1;
                            rx_sh   <= {rx_sh[B-2:0], i_spi_miso};
                            bit_cnt <= bit_cnt + 1'b1;
`ifdef JPL_ADC_SPI_LEADCHK_EN
                            if ((bit_cnt < BW'(LEAD)) && i_spi_miso)
                                lead_err <= 1'b1;
`endif
                        end else if (bit_cnt == BW'(FRAME)) begin
                            state  <= HOLD;
                            mosi_q <= 1'b0;
                        end else begin
                            sclk_q <= 1'b0;
                            mosi_q <= tx_sh[FRAME-1];
                            tx_sh  <= tx_sh << 1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        cs_n_q  <= 1'b1;
                        state   <= QUIET;
                        chan_q  <= chan_nxt;
`ifdef JPL_ADC_SPI_LEADCHK_EN
                        if (lead_err) begin
                            ffr_q <= 1'b1;
                        end else begin
                            valid_q  <= 1'b1;
                            raw_q    <= rx_sh;
                            chan_o_q <= chan_q;
                        end
`else
                        valid_q  <= 1'b1;
                        raw_q    <= rx_sh;
                        chan_o_q <= chan_q;
`endif
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                QUIET: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (!start) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase

            // Frame start; from QUIET this skips IDLE so an overrun or a zero
            // period gives back-to-back frames at the minimum spacing.
            if (start) begin
                state   <= SETUP;
                busy_q  <= 1'b1;
                run     <= 1'b1;
                cs_n_q  <= 1'b0;
                sclk_q  <= 1'b1;
                mosi_q  <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
                per_cnt <= '0;
                per_q   <= i_period;
                tx_sh   <= tx_load;
                if ((i_period != 16'd0) && ({16'd0, i_period} < PMIN))
                    ovr_q <= 1'b1;
`ifdef JPL_ADC_SPI_LEADCHK_EN
                lead_err <= 1'b0;
`endif
            end
        end
    end

    assign o_spi_cs_n      = cs_n_q;
    assign o_spi_sclk      = sclk_q;
    assign o_spi_mosi      = mosi_q;
    assign o_adc_raw       = raw_q;
    assign o_adc_raw_valid = valid_q;
    assign o_adc_chan      = chan_o_q;
    assign o_busy          = busy_q;
    assign o_fault_overrun = ovr_q;
`ifdef JPL_ADC_SPI_LEADCHK_EN
    assign o_fault_frame   = ffr_q;
`else
    assign o_fault_frame   = 1'b0;
`endif

endmodule

// File: tb/tb_jpl_adc_spi_reader.sv
// Testbench for jpl_adc_spi_reader: a behavioural ADC slave drives MISO and
// decodes MOSI, pushing the expected result of every frame into a scoreboard
// at CS fall; an independent monitor pops and compares on each output strobe.

module tb_jpl_adc_spi_reader;

    localparam int B = 12, N = 2, ADDR_W = 3, ADDR_POS = 2, FRAME = 16, CLKDIV = 4;
    localparam int CW    = 1;
    localparam int PMIN  = CLKDIV * (2 * FRAME + 3);
    localparam int CSLOW = CLKDIV * (2 * FRAME + 2);
`ifdef JPL_ADC_SPI_LEADCHK_EN
    localparam bit LEADCHK = 1'b1;
`else
    localparam bit LEADCHK = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_enable = 1'b0;
    logic [15:0]   i_period = 16'd0;
    logic          i_spi_miso = 1'b0;
    logic          o_spi_cs_n, o_spi_sclk, o_spi_mosi;
    logic [B-1:0]  o_adc_raw;
    logic          o_adc_raw_valid;
    logic [CW-1:0] o_adc_chan;
    logic          o_busy, o_fault_overrun, o_fault_frame;

    jpl_adc_spi_reader #(
        .B(B), .N(N), .ADDR_W(ADDR_W), .ADDR_POS(ADDR_POS), .FRAME(FRAME), .CLKDIV(CLKDIV)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_period(i_period),
        .o_spi_cs_n(o_spi_cs_n), .o_spi_sclk(o_spi_sclk), .o_spi_mosi(o_spi_mosi),
        .i_spi_miso(i_spi_miso), .o_adc_raw(o_adc_raw), .o_adc_raw_valid(o_adc_raw_valid),
        .o_adc_chan(o_adc_chan), .o_busy(o_busy), .o_fault_overrun(o_fault_overrun),
        .o_fault_frame(o_fault_frame)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int  chan;
        int  val;
        bit  bad;
        bit  ovr;
        longint t_fall;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0, n_fail = 0;
    int   n_falls = 0, n_done = 0;
    int   ch_val[N];
    bit   inject_req = 1'b0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- ADC slave model + expectation source ----------------
    bit     prev_cs = 1'b1, prev_sclk = 1'b1;
    int     k = 0, dev_chan = 0, cur_tag = 0;
    bit     have_prev = 1'b0, ovr_run = 1'b0;
    longint t_prev = 0, t_fall = 0;
    int     p_prev = 0;
    int     miso_word = 0, mosi_word = 0, n_rise = 0, n_fsclk = 0;
    exp_t   rm;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            k = 0; dev_chan = 0; have_prev = 1'b0; ovr_run = 1'b0;
            sb.delete();
            i_spi_miso = 1'b0;
            prev_cs = 1'b1; prev_sclk = 1'b1;
        end else begin
            if (!i_enable && !o_busy) begin
                k = 0; dev_chan = 0; have_prev = 1'b0; ovr_run = 1'b0;
            end
            if (prev_cs && !o_spi_cs_n) begin
                n_falls++;
                if (have_prev)
                    chk("frame_spacing", ($time - t_prev) / 10, (p_prev < PMIN) ? PMIN : p_prev);
                have_prev = 1'b1; t_prev = $time; p_prev = int'(i_period);
                if (i_period != 0 && int'(i_period) < PMIN) ovr_run = 1'b1;
                cur_tag = k % N; k++;
                t_fall = $time;
                rm.chan = cur_tag; rm.val = ch_val[dev_chan]; rm.ovr = ovr_run; rm.t_fall = $time;
                miso_word = rm.val;
                rm.bad = 1'b0;
                if (inject_req) begin
                    miso_word = miso_word | (1 << (FRAME - 1 - $urandom_range(0, FRAME - B - 1)));
                    inject_req = 1'b0;
                    rm.bad = LEADCHK;
                end
                sb.push_back(rm);
                n_rise = 0; n_fsclk = 0; mosi_word = 0;
            end
            if (!o_spi_cs_n) begin
                if (prev_sclk && !o_spi_sclk && n_fsclk < FRAME) begin
                    i_spi_miso = miso_word[FRAME - 1 - n_fsclk];
                    n_fsclk++;
                end
                if (!prev_sclk && o_spi_sclk) begin
                    mosi_word = (mosi_word << 1) | int'(o_spi_mosi);
                    n_rise++;
                end
            end
            if (!prev_cs && o_spi_cs_n) begin
                chk("cs_low_cycles", ($time - t_fall) / 10, CSLOW);
                chk("sclk_rises", n_rise, FRAME);
                chk("mosi_word", mosi_word, ((cur_tag + 1) % N) << (FRAME - ADDR_POS - ADDR_W));
                dev_chan = ((mosi_word >> (FRAME - ADDR_POS - ADDR_W)) & 7) % N;
                i_spi_miso = 1'b0;
            end
            prev_cs = o_spi_cs_n; prev_sclk = o_spi_sclk;
        end
    end

    // ---------------- output monitor ----------------
    bit   prev_v = 1'b0;
    exp_t rn;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (o_adc_raw_valid || o_fault_frame) begin
                if (o_adc_raw_valid) chk("strobe_gap", prev_v, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    rn = sb.pop_front();
                    chk("fault_frame", o_fault_frame, rn.bad);
                    chk("valid", o_adc_raw_valid, !rn.bad);
                    if (!rn.bad) begin
                        chk("raw", o_adc_raw, rn.val);
                        chk("chan", o_adc_chan, rn.chan);
                    end
                    chk("strobe_latency", ($time - rn.t_fall) / 10, CSLOW);
                    chk("overrun_at_strobe", o_fault_overrun, rn.ovr);
                    n_done++;
                end
            end
            prev_v = o_adc_raw_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input int n, input int budget);
        int target = n_done + n;
        int c = 0;
        while (n_done < target && c < budget) begin
            @(negedge i_clk); c++;
        end
        chk("frames_completed_in_time", n_done >= target, 1);
    endtask

    task automatic stop_idle();
        int c = 0;
        i_enable = 1'b0;
        while (o_busy && c < 400) begin
            @(negedge i_clk); c++;
        end
        chk("idle_reached", o_busy, 0);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic set_vals();
        for (int i = 0; i < N; i++) ch_val[i] = int'($urandom_range(1, 4095));
    endtask

    task automatic wait_fall();
        int f0 = n_falls;
        int c = 0;
        while (n_falls == f0 && c < 1000) begin
            @(negedge i_clk); c++;
        end
        chk("frame_started", n_falls > f0, 1);
    endtask

    int f_save, d_save;

    initial begin
        ch_val[0] = 'h0A5B; ch_val[1] = 'h0F00;
        repeat (3) @(negedge i_clk);
        chk("rst_cs_n", o_spi_cs_n, 1);
        chk("rst_sclk", o_spi_sclk, 1);
        chk("rst_mosi", o_spi_mosi, 0);
        chk("rst_raw", o_adc_raw, 0);
        chk("rst_valid", o_adc_raw_valid, 0);
        chk("rst_chan", o_adc_chan, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_overrun", o_fault_overrun, 0);
        chk("rst_fault_frame", o_fault_frame, 0);
        i_rst_n = 1'b1;
        repeat (20) @(negedge i_clk);
        chk("idle_no_cs_when_disabled", o_spi_cs_n, 1);

        // Nominal cadence with the fixed sample values.
        i_period = 16'd200; i_enable = 1'b1;
        wait_done(6, 6 * 200 + 400);
        stop_idle();

        // Period shorter than a frame: overrun sets, clears once idle.
        set_vals(); i_period = 16'd100; i_enable = 1'b1;
        wait_done(5, 5 * PMIN + 400);
        chk("overrun_set", o_fault_overrun, 1);
        stop_idle();
        chk("overrun_cleared", o_fault_overrun, 0);

        // Back-to-back frames, one with a corrupted leading bit.
        set_vals(); i_period = 16'd0; i_enable = 1'b1;
        wait_done(2, 2 * PMIN + 400);
        inject_req = 1'b1;
        wait_done(4, 4 * PMIN + 400);
        chk("overrun_zero_period", o_fault_overrun, 0);
        stop_idle();

        // Randomised periods around the minimum spacing.
        for (int it = 0; it < 3; it++) begin
            set_vals();
            case (it)
                0: i_period = 16'($urandom_range(1, PMIN - 1));
                1: i_period = 16'($urandom_range(PMIN + 1, 260));
                default: i_period = 16'(PMIN);
            endcase
            i_enable = 1'b1;
            wait_done(4, 4 * 300 + 400);
            stop_idle();
        end

        // Enable dropped mid-frame: that frame still delivers its strobe.
        set_vals(); i_period = 16'd200; i_enable = 1'b1;
        wait_fall();
        f_save = n_falls; d_save = n_done;
        repeat (50) @(negedge i_clk);
        stop_idle();
        chk("drop_strobe_delivered", n_done - d_save, 1);
        repeat (200) @(negedge i_clk);
        chk("no_frame_when_disabled", n_falls, f_save);

        // Re-enable restarts at channel 0 (checked by the monitor's tag compare).
        set_vals(); i_enable = 1'b1;
        wait_done(3, 3 * 200 + 400);

        // Reset in the middle of SHIFT.
        wait_fall();
        repeat (40) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", o_spi_cs_n, 1);
        chk("midrst_sclk", o_spi_sclk, 1);
        chk("midrst_raw", o_adc_raw, 0);
        chk("midrst_valid", o_adc_raw_valid, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_chan", o_adc_chan, 0);
        i_enable = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        f_save = n_falls; d_save = n_done;
        repeat (250) @(negedge i_clk);
        chk("postrst_no_frame", n_falls, f_save);
        chk("postrst_no_strobe", n_done, d_save);
        chk("postrst_cs_n", o_spi_cs_n, 1);
        chk("postrst_mosi", o_spi_mosi, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
